sysid_read_arbiter: RTL and testbench
=====================================

SYSID_READ_ARBITER -- requirements
Module: sysid_read_arbiter

Interface
REQ-001 Parameter EXPECTED_ID, default 32'd0, is the value the system ID slave SHALL return at address 0.
REQ-002 Parameter EXPECTED_TIMESTAMP, default 32'd1671591062, is the value the system ID slave SHALL return at address 1.
REQ-003 clock  in  1  single clock; all state SHALL update on its rising edge.
REQ-004 reset  in  1  asynchronous, active-high reset.
REQ-005 m0_read  in  1  requester 0 read strobe; held high until accepted.
REQ-006 m0_address  in  1  requester 0 word address (0 = ID, 1 = timestamp).
REQ-007 m0_waitrequest  out  1  high = requester 0 read not accepted this cycle.
REQ-008 m0_readdata  out  32  requester 0 read data, valid only with m0_readdatavalid.
REQ-009 m0_readdatavalid  out  1  one-cycle pulse marking requester 0 returned data.
REQ-010 m1_read, m1_address, m1_waitrequest, m1_readdata, m1_readdatavalid SHALL have the same directions, widths and meanings as REQ-005..REQ-009, for requester 1.
REQ-011 sid_address  out  1  address driven to the shared system ID slave.
REQ-012 sid_readdata  in  32  combinational read data from the system ID slave, valid in the same cycle as sid_address.
REQ-013 recheck  in  1  single-cycle request to rerun the ID check.
REQ-014 check_done  out  1  high once an ID check has completed.
REQ-015 id_ok  out  1  high when the last completed check matched both expected values.

Function
REQ-016 FSM states SHALL be CHK_ID, CHK_TS, IDLE and RESP; the reset state is CHK_ID.
REQ-017 CHK_ID: drive sid_address=0, register (sid_readdata==EXPECTED_ID), then go to CHK_TS.
REQ-018 CHK_TS: drive sid_address=1, compare sid_readdata with EXPECTED_TIMESTAMP, then go to IDLE.
REQ-019 On leaving CHK_TS, check_done SHALL be set to 1 and id_ok SHALL be set to the AND of both comparisons; both values SHALL hold until the next reset or recheck.
REQ-020 In CHK_ID, CHK_TS and RESP, both waitrequest outputs SHALL be high.
REQ-021 IDLE, recheck high: recheck SHALL take priority over pending reads; clear check_done and id_ok, go to CHK_ID, grant nothing.
REQ-022 IDLE, recheck low, exactly one mN_read high: grant requester N.
REQ-023 IDLE, recheck low, both reads high: grant the requester not granted most recently (round-robin); the last-grant register resets to 1, so requester 0 wins the first tie.
REQ-024 Grant cycle actions:
- drive sid_address = mN_address;
- drive mN_waitrequest low for that cycle only;
- capture sid_readdata into the shared data register;
- record N as last grant;
- go to RESP.
REQ-025 RESP: assert mN_readdatavalid for exactly one cycle with mN_readdata = captured data, then return to IDLE. Read latency is 1 cycle after acceptance; peak throughput is one read per 2 cycles.
REQ-026 The non-granted requester SHALL keep waitrequest high, and its pending read SHALL stay queued with no loss.
REQ-027 Outside RESP, mN_readdatavalid SHALL be 0 and the readdata outputs SHALL hold their last value.
REQ-028 In IDLE with no grant, sid_address SHALL be 0.
REQ-029 Reads issued before check_done SHALL be stalled, not rejected.

Reset
REQ-030 While reset is high, outputs SHALL immediately take these values:
- m0_waitrequest = m1_waitrequest = 1;
- m0_readdatavalid = m1_readdatavalid = 0;
- m0_readdata = m1_readdata = 0;
- sid_address = 0;
- check_done = id_ok = 0.
REQ-031 Reset asserted mid-check or mid-read SHALL abort the operation and drop any pending response. After release, the block SHALL restart at CHK_ID.

Verification
REQ-032 Release reset with a slave returning 0 and 1671591062: check_done=1 and id_ok=1 on the 2nd clock edge after release; no readdatavalid pulse.
REQ-033 Same sequence with the timestamp slave value 32'h12345678: check_done=1, id_ok=0.
REQ-034 After the check, m0 reads address 1: m0_waitrequest=0 in the grant cycle, then next cycle m0_readdatavalid=1 with m0_readdata=1671591062; m1 outputs are unchanged.
REQ-035 m0 and m1 both hold reads (addresses 0 and 1) continuously, starting right after the check: grants alternate m0, m1, m0, ..., each returning its correct value, with no request lost.
REQ-036 recheck pulsed in IDLE while m1_read is high: check_done falls, CHK_ID/CHK_TS rerun, and m1 is granted only after check_done is high again.
REQ-037 Reset asserted in RESP: readdatavalid=0 immediately; after release the check reruns, and the stale response is never delivered.

Source files
------------

// File: rtl/sysid_read_arbiter.sv
// sysid_read_arbiter
//   Verifies a system ID slave at start-up (ID word, then timestamp word) and
//   then shares that slave between two read requesters with round-robin
//   arbitration. Each accepted read returns data exactly one cycle later.
//
// Ports
//   clock, reset                  : single clock, asynchronous active-high reset
//   m0_read/m0_address            : requester 0 read strobe and word address
//   m0_waitrequest                : low only in the cycle requester 0 is accepted
//   m0_readdata/m0_readdatavalid  : requester 0 returned data and its strobe
//   m1_*                          : same set for requester 1
//   sid_address/sid_readdata      : shared system ID slave (combinational read)
//   recheck                       : rerun the ID check (honoured while idle)
//   check_done/id_ok              : check completed / last check matched
module sysid_read_arbiter #(
  parameter logic [31:0] EXPECTED_ID        = 32'd0,
  parameter logic [31:0] EXPECTED_TIMESTAMP = 32'd1671591062
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        m0_read,
  input  logic        m0_address,
  output logic        m0_waitrequest,
  output logic [31:0] m0_readdata,
  output logic        m0_readdatavalid,
  input  logic        m1_read,
  input  logic        m1_address,
  output logic        m1_waitrequest,
  output logic [31:0] m1_readdata,
  output logic        m1_readdatavalid,
  output logic        sid_address,
  input  logic [31:0] sid_readdata,
  input  logic        recheck,
  output logic        check_done,
  output logic        id_ok
);

  typedef enum logic [1:0] {
    CHK_ID = 2'd0,
    CHK_TS = 2'd1,
    IDLE   = 2'd2,
    RESP   = 2'd3
  } state_t;

  state_t      state_reg, state_next;
  logic        last_grant_reg;   // requester granted most recently
  logic        resp_sel_reg;     // requester owed the response in RESP
  logic        id_match_reg;     // result of the ID word comparison
  logic        check_done_reg;
  logic        id_ok_reg;
  logic [31:0] m0_readdata_reg;
  logic [31:0] m1_readdata_reg;
  logic        grant_valid;
  logic        grant_sel;

  always_comb begin
    state_next     = state_reg;
    sid_address    = 1'b0;
    m0_waitrequest = 1'b1;
    m1_waitrequest = 1'b1;
    grant_valid    = 1'b0;
    grant_sel      = 1'b0;
    case (state_reg)
      CHK_ID: state_next = CHK_TS;
      CHK_TS: begin
        sid_address = 1'b1;
        state_next  = IDLE;
      end
      IDLE: begin
        if (recheck) begin
          state_next = CHK_ID;
        end else if (m0_read || m1_read) begin
          grant_valid = 1'b1;
          // On a tie the requester not served last wins; otherwise the
          // single active requester is taken.
          grant_sel      = (m0_read && m1_read) ? ~last_grant_reg : m1_read;
          sid_address    = grant_sel ? m1_address : m0_address;
          m0_waitrequest = grant_sel;
          m1_waitrequest = ~grant_sel;
          state_next     = RESP;
        end
      end
      RESP:    state_next = IDLE;
      default: state_next = CHK_ID;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_reg       <= CHK_ID;
      last_grant_reg  <= 1'b1;
      resp_sel_reg    <= 1'b0;
      id_match_reg    <= 1'b0;
      check_done_reg  <= 1'b0;
      id_ok_reg       <= 1'b0;
      m0_readdata_reg <= 32'd0;
      m1_readdata_reg <= 32'd0;
    end else begin
      state_reg <= state_next;
      if (state_reg == CHK_ID) begin
        id_match_reg <= (sid_readdata == EXPECTED_ID);
      end
      if (state_reg == CHK_TS) begin
        check_done_reg <= 1'b1;
        id_ok_reg      <= id_match_reg && (sid_readdata == EXPECTED_TIMESTAMP);
      end
      if (state_reg == IDLE && recheck) begin
        check_done_reg <= 1'b0;
        id_ok_reg      <= 1'b0;
      end
      if (grant_valid) begin
        last_grant_reg <= grant_sel;
        resp_sel_reg   <= grant_sel;
        // Capturing straight into the granted requester's output register
        // presents the data in RESP and holds it afterwards, leaving the
        // other requester's last value untouched.
        if (grant_sel) begin
          m1_readdata_reg <= sid_readdata;
        end else begin
          m0_readdata_reg <= sid_readdata;
        end
      end
    end
  end

  assign m0_readdatavalid = (state_reg == RESP) && !resp_sel_reg;
  assign m1_readdatavalid = (state_reg == RESP) &&  resp_sel_reg;
  assign m0_readdata      = m0_readdata_reg;
  assign m1_readdata      = m1_readdata_reg;
  assign check_done       = check_done_reg;
  assign id_ok            = id_ok_reg;

endmodule

// File: tb/tb_sysid_read_arbiter.sv
// Directed bench for sysid_read_arbiter with a behavioural system ID slave.
module tb_sysid_read_arbiter;

  localparam logic [31:0] TS_GOOD = 32'd1671591062;
  localparam logic [31:0] ID_ALT  = 32'hCAFE_0000;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        m0_read = 1'b0, m0_address = 1'b0;
  logic        m1_read = 1'b0, m1_address = 1'b0;
  logic        recheck = 1'b0;
  logic        m0_waitrequest, m0_readdatavalid;
  logic        m1_waitrequest, m1_readdatavalid;
  logic [31:0] m0_readdata, m1_readdata;
  logic        sid_address;
  logic [31:0] sid_readdata;
  logic        check_done, id_ok;
  logic [31:0] id_val = 32'd0;
  logic [31:0] ts_val = TS_GOOD;

  int vectors = 0;
  int fails   = 0;

  always #5 clock = ~clock;

  assign sid_readdata = sid_address ? ts_val : id_val;

  sysid_read_arbiter dut (
    .clock            (clock),
    .reset            (reset),
    .m0_read          (m0_read),
    .m0_address       (m0_address),
    .m0_waitrequest   (m0_waitrequest),
    .m0_readdata      (m0_readdata),
    .m0_readdatavalid (m0_readdatavalid),
    .m1_read          (m1_read),
    .m1_address       (m1_address),
    .m1_waitrequest   (m1_waitrequest),
    .m1_readdata      (m1_readdata),
    .m1_readdatavalid (m1_readdatavalid),
    .sid_address      (sid_address),
    .sid_readdata     (sid_readdata),
    .recheck          (recheck),
    .check_done       (check_done),
    .id_ok            (id_ok)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance to 1 time unit after the next rising edge.
  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // Reset for a few cycles, release just after an edge, run the two check cycles.
  task automatic do_reset_and_check();
    reset = 1'b1;
    repeat (3) step();
    reset = 1'b0;
    step();
    chk("done_after_edge1", check_done, 0);
    step();
  endtask

  initial begin
    // Reset values
    #2;
    chk("rst_m0_wait", m0_waitrequest, 1);
    chk("rst_m1_wait", m1_waitrequest, 1);
    chk("rst_m0_valid", m0_readdatavalid, 0);
    chk("rst_m1_valid", m1_readdatavalid, 0);
    chk("rst_m0_data", m0_readdata, 0);
    chk("rst_m1_data", m1_readdata, 0);
    chk("rst_sid_addr", sid_address, 0);
    chk("rst_done", check_done, 0);
    chk("rst_ok", id_ok, 0);

    // Good slave: check completes on the 2nd edge after release
    do_reset_and_check();
    chk("good_done", check_done, 1);
    chk("good_ok", id_ok, 1);
    chk("good_m0_valid", m0_readdatavalid, 0);
    chk("good_m1_valid", m1_readdatavalid, 0);
    chk("idle_sid_addr", sid_address, 0);

    // Both requesters hold reads continuously; m0 wins first tie, then alternate
    id_val = ID_ALT;
    m0_read = 1'b1; m0_address = 1'b0;
    m1_read = 1'b1; m1_address = 1'b1;
    for (int k = 0; k < 4; k++) begin
      #1;
      if (k % 2 == 0) begin
        chk("rr_m0_wait_grant", m0_waitrequest, 0);
        chk("rr_m1_wait_hold", m1_waitrequest, 1);
        chk("rr_sid_addr0", sid_address, 0);
      end else begin
        chk("rr_m1_wait_grant", m1_waitrequest, 0);
        chk("rr_m0_wait_hold", m0_waitrequest, 1);
        chk("rr_sid_addr1", sid_address, 1);
      end
      step();
      if (k % 2 == 0) begin
        chk("rr_m0_valid", m0_readdatavalid, 1);
        chk("rr_m1_valid_lo", m1_readdatavalid, 0);
        chk("rr_m0_data", m0_readdata, ID_ALT);
      end else begin
        chk("rr_m1_valid", m1_readdatavalid, 1);
        chk("rr_m0_valid_lo", m0_readdatavalid, 0);
        chk("rr_m1_data", m1_readdata, TS_GOOD);
      end
      chk("rr_resp_m0_wait", m0_waitrequest, 1);
      chk("rr_resp_m1_wait", m1_waitrequest, 1);
      step();
      chk("rr_idle_m0_valid", m0_readdatavalid, 0);
      chk("rr_idle_m1_valid", m1_readdatavalid, 0);
    end
    m0_read = 1'b0; m1_read = 1'b0;
    id_val = 32'd0;

    // Single m0 read of the timestamp; m1 outputs must not move
    step();
    m0_read = 1'b1; m0_address = 1'b1;
    #1;
    chk("m0_single_wait", m0_waitrequest, 0);
    chk("m0_single_m1_wait", m1_waitrequest, 1);
    chk("m0_single_sid", sid_address, 1);
    step();
    m0_read = 1'b0;
    chk("m0_single_valid", m0_readdatavalid, 1);
    chk("m0_single_data", m0_readdata, TS_GOOD);
    chk("m0_single_m1_valid", m1_readdatavalid, 0);
    chk("m0_single_m1_data", m1_readdata, TS_GOOD);
    step();
    chk("m0_single_valid_drop", m0_readdatavalid, 0);
    chk("m0_single_data_hold", m0_readdata, TS_GOOD);

    // Recheck takes priority over a pending m1 read
    m1_read = 1'b1; m1_address = 1'b0; recheck = 1'b1;
    #1;
    chk("rchk_m1_wait", m1_waitrequest, 1);
    step();
    recheck = 1'b0;
    chk("rchk_done_fall", check_done, 0);
    chk("rchk_ok_fall", id_ok, 0);
    chk("rchk_chkid_wait", m1_waitrequest, 1);
    chk("rchk_chkid_valid", m1_readdatavalid, 0);
    step();
    chk("rchk_chkts_wait", m1_waitrequest, 1);
    chk("rchk_chkts_sid", sid_address, 1);
    chk("rchk_chkts_done", check_done, 0);
    step();
    chk("rchk_done_again", check_done, 1);
    chk("rchk_ok_again", id_ok, 1);
    chk("rchk_m1_grant", m1_waitrequest, 0);
    step();
    m1_read = 1'b0;
    chk("rchk_m1_valid", m1_readdatavalid, 1);
    chk("rchk_m1_data", m1_readdata, 32'd0);
    step();

    // Reset in RESP drops the response
    m0_read = 1'b1; m0_address = 1'b1;
    step();
    m0_read = 1'b0;
    chk("rresp_valid_before", m0_readdatavalid, 1);
    #2;
    reset = 1'b1;
    #1;
    chk("rresp_valid_now", m0_readdatavalid, 0);
    chk("rresp_data_now", m0_readdata, 0);
    chk("rresp_done_now", check_done, 0);
    chk("rresp_wait_now", m0_waitrequest, 1);
    step();
    reset = 1'b0;
    step();
    chk("rresp_e1_valid", m0_readdatavalid, 0);
    chk("rresp_e1_done", check_done, 0);
    step();
    chk("rresp_e2_valid", m0_readdatavalid, 0);
    chk("rresp_e2_done", check_done, 1);
    step();
    chk("rresp_e3_valid", m0_readdatavalid, 0);
    chk("rresp_e3_data", m0_readdata, 0);

    // Wrong timestamp
    ts_val = 32'h12345678;
    do_reset_and_check();
    chk("badts_done", check_done, 1);
    chk("badts_ok", id_ok, 0);

    // Wrong ID, good timestamp
    ts_val = TS_GOOD;
    id_val = 32'd1;
    do_reset_and_check();
    chk("badid_done", check_done, 1);
    chk("badid_ok", id_ok, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
    $finish;
  end

endmodule
